// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light controller and its safety monitor.
// Holds the lamp encodings ({R,Y,G}, one-hot), the monitor fault codes, the
// monitor state encoding and the bit positions of the per-direction
// violation flag vector produced by traffic_lamp_checker.
// ---------------------------------------------------------------------------
package traffic_pkg;

   // Lamp patterns shared by the controller and the monitor
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // Fault codes; a smaller number means a higher priority
   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_ILLEGAL  = 3'd1;
   localparam logic [2:0] FC_CONFLICT = 3'd2;
   localparam logic [2:0] FC_TRANS    = 3'd3;
   localparam logic [2:0] FC_YSHORT   = 3'd4;
   localparam logic [2:0] FC_YLONG    = 3'd5;
   localparam logic [2:0] FC_GWATCH   = 3'd6;

   // Monitor states
   typedef enum logic [1:0] {
      ST_MON     = 2'd0,
      ST_FAULT   = 2'd1,
      ST_ALL_RED = 2'd2
   } mon_state_e;

   // Bit positions inside a per-direction violation flag vector
   localparam int VF_ILLEGAL = 0;
   localparam int VF_TRANS   = 1;
   localparam int VF_YSHORT  = 2;
   localparam int VF_YLONG   = 3;
   localparam int VF_GWATCH  = 4;
   localparam int VF_W       = 5;

   // True when a lamp vector is exactly one of the three legal patterns
   function automatic logic lamp_legal(input logic [2:0] lamp);
      return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
   endfunction

endpackage

// File: rtl/traffic_lamp_checker.sv
// ---------------------------------------------------------------------------
// traffic_lamp_checker
// Tracks one direction's lamp history and flags per-direction violations.
// The history (previous lamp value and a saturating duration counter) is
// updated on every edge regardless of what the monitor is doing; the flags
// are purely combinational on the current input against that history.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   led_in in 3 lamp vector from the controller for this direction
//   viol   out 5 violation flags, bit positions VF_* from traffic_pkg
// ---------------------------------------------------------------------------
module traffic_lamp_checker
   import traffic_pkg::*;
#(
   parameter int Y_MIN = 5,
   parameter int Y_MAX = 6,
   parameter int G_MAX = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      led_in,
   output logic [VF_W-1:0] viol
);

   localparam int CNT_MAX = (G_MAX > Y_MAX) ? G_MAX : Y_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] Y_MIN_C = CNT_W'(Y_MIN);
   localparam logic [CNT_W-1:0] Y_MAX_C = CNT_W'(Y_MAX);
   localparam logic [CNT_W-1:0] G_MAX_C = CNT_W'(G_MAX);

   logic [2:0]       prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             changed;
   logic             step_ok;

   assign changed = (led_in != prev_q);

   // History update: any change restarts the duration count at 1 (the new
   // value has now been seen once); a steady value counts up and sticks at
   // all-ones so long phases never wrap back into a "short" duration.
   always_comb begin
      prev_d = led_in;
      cnt_d  = cnt_q;
      if (changed) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // History registers, reset to "red seen for zero cycles"
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= LAMP_RED;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

   // Violation flags. Only R->G, G->Y and Y->R count as legal changes; the
   // duration checks look at how long the previous value had been held.
   always_comb begin
      step_ok = ((prev_q == LAMP_RED) && (led_in == LAMP_GRN)) ||
                ((prev_q == LAMP_GRN) && (led_in == LAMP_YEL)) ||
                ((prev_q == LAMP_YEL) && (led_in == LAMP_RED));
      viol             = '0;
      viol[VF_ILLEGAL] = !lamp_legal(led_in);
      viol[VF_TRANS]   = changed && !step_ok;
      viol[VF_YSHORT]  = changed && (prev_q == LAMP_YEL) && (led_in == LAMP_RED) &&
                         (cnt_q < Y_MIN_C);
      viol[VF_YLONG]   = !changed && (led_in == LAMP_YEL) && (cnt_q >= Y_MAX_C);
      viol[VF_GWATCH]  = !changed && (led_in == LAMP_GRN) && (cnt_q >= G_MAX_C);
   end

endmodule

// File: rtl/traffic_safety_monitor.sv
// ---------------------------------------------------------------------------
// traffic_safety_monitor
// Runtime safety monitor sitting between the traffic-light controller and
// the lamp drivers. In normal operation the lamp vectors pass through with
// one cycle of latency. The first violation latches a fault code and drives
// flashing yellow on both directions; a clear request leads back to normal
// pass-through via an all-red phase.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   led_in1    in 3 direction-1 lamps from the controller ({R,Y,G})
//   led_in2    in 3 direction-2 lamps from the controller ({R,Y,G})
//   fault_clr  in   fault clear request, sampled while in FAULT
//   led_out1   out 3 direction-1 lamp drive
//   led_out2   out 3 direction-2 lamp drive
//   fault      out  fault latched
//   fault_code out 3 first fault cause, 0 = none
//   fault_dir  out 2 direction(s) involved, bit0 = dir1, bit1 = dir2
// ---------------------------------------------------------------------------
module traffic_safety_monitor
   import traffic_pkg::*;
#(
   parameter int Y_MIN      = 5,
   parameter int Y_MAX      = 6,
   parameter int G_MAX      = 12,
   parameter int FLASH_DIV  = 4,
   parameter int ALLRED_CYC = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] led_in1,
   input  logic [2:0] led_in2,
   input  logic       fault_clr,
   output logic [2:0] led_out1,
   output logic [2:0] led_out2,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_dir
);

   localparam int FL_W = (2 * FLASH_DIV > 1) ? $clog2(2 * FLASH_DIV) : 1;
   localparam int AR_W = (ALLRED_CYC > 0) ? $clog2(ALLRED_CYC + 1) : 1;

   localparam logic [FL_W-1:0] FL_LAST = FL_W'(2 * FLASH_DIV - 1);
   localparam logic [FL_W-1:0] FL_ON   = FL_W'(FLASH_DIV);
   localparam logic [AR_W-1:0] AR_MIN  = AR_W'(ALLRED_CYC);

   mon_state_e state_q, state_d;

   logic [2:0]      led_out1_q, led_out1_d;
   logic [2:0]      led_out2_q, led_out2_d;
   logic            fault_q, fault_d;
   logic [2:0]      code_q, code_d;
   logic [1:0]      dir_q, dir_d;
   logic [FL_W-1:0] flash_q, flash_d;
   logic [AR_W-1:0] allred_q, allred_d;

   logic [VF_W-1:0] viol1, viol2;
   logic            conflict;
   logic [2:0]      viol_code;
   logic [1:0]      viol_dir;
   logic [FL_W-1:0] flash_step;
   logic [AR_W-1:0] allred_step;
   logic            exit_ok;

   traffic_lamp_checker #(
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX),
      .G_MAX (G_MAX)
   ) u_check1 (
      .clk    (clk),
      .rst    (rst),
      .led_in (led_in1),
      .viol   (viol1)
   );

   traffic_lamp_checker #(
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX),
      .G_MAX (G_MAX)
   ) u_check2 (
      .clk    (clk),
      .rst    (rst),
      .led_in (led_in2),
      .viol   (viol2)
   );

   // Both directions legal and neither showing red means crossing traffic
   // could be released at the same time.
   assign conflict = lamp_legal(led_in1) && lamp_legal(led_in2) &&
                     (led_in1 != LAMP_RED) && (led_in2 != LAMP_RED);

   // The flash counter wraps over one full on/off period; the all-red counter
   // sticks at its maximum since only "at least N cycles" matters.
   assign flash_step  = (flash_q == FL_LAST) ? '0 : flash_q + 1'b1;
   assign allred_step = (allred_q == '1) ? allred_q : allred_q + 1'b1;

   // Leaving all-red is only safe once the controller itself is showing a
   // sane picture with at least one direction stopped.
   assign exit_ok = lamp_legal(led_in1) && lamp_legal(led_in2) &&
                    ((led_in1 == LAMP_RED) || (led_in2 == LAMP_RED));

   // Priority encoder: the lowest fault code wins. The direction mask marks
   // every direction that raised the winning code; a conflict always
   // involves both directions.
   always_comb begin
      viol_code = FC_NONE;
      viol_dir  = 2'b00;
      if (viol1[VF_ILLEGAL] || viol2[VF_ILLEGAL]) begin
         viol_code = FC_ILLEGAL;
         viol_dir  = {viol2[VF_ILLEGAL], viol1[VF_ILLEGAL]};
      end else if (conflict) begin
         viol_code = FC_CONFLICT;
         viol_dir  = 2'b11;
      end else if (viol1[VF_TRANS] || viol2[VF_TRANS]) begin
         viol_code = FC_TRANS;
         viol_dir  = {viol2[VF_TRANS], viol1[VF_TRANS]};
      end else if (viol1[VF_YSHORT] || viol2[VF_YSHORT]) begin
         viol_code = FC_YSHORT;
         viol_dir  = {viol2[VF_YSHORT], viol1[VF_YSHORT]};
      end else if (viol1[VF_YLONG] || viol2[VF_YLONG]) begin
         viol_code = FC_YLONG;
         viol_dir  = {viol2[VF_YLONG], viol1[VF_YLONG]};
      end else if (viol1[VF_GWATCH] || viol2[VF_GWATCH]) begin
         viol_code = FC_GWATCH;
         viol_dir  = {viol2[VF_GWATCH], viol1[VF_GWATCH]};
      end
   end

   // Next-state and next-output logic. A violating input is never forwarded:
   // the same edge that sees it switches the outputs to yellow. In FAULT the
   // flash phase is derived from the counter value being loaded, so the entry
   // edge (counter 0) opens the first "on" half-period.
   always_comb begin
      state_d    = state_q;
      led_out1_d = led_out1_q;
      led_out2_d = led_out2_q;
      fault_d    = fault_q;
      code_d     = code_q;
      dir_d      = dir_q;
      flash_d    = flash_q;
      allred_d   = allred_q;
      case (state_q)
         ST_MON: begin
            if (viol_code != FC_NONE) begin
               state_d    = ST_FAULT;
               fault_d    = 1'b1;
               code_d     = viol_code;
               dir_d      = viol_dir;
               flash_d    = '0;
               led_out1_d = LAMP_YEL;
               led_out2_d = LAMP_YEL;
            end else begin
               led_out1_d = led_in1;
               led_out2_d = led_in2;
            end
         end
         ST_FAULT: begin
            if (fault_clr) begin
               state_d    = ST_ALL_RED;
               fault_d    = 1'b0;
               code_d     = FC_NONE;
               dir_d      = 2'b00;
               flash_d    = '0;
               allred_d   = '0;
               led_out1_d = LAMP_RED;
               led_out2_d = LAMP_RED;
            end else begin
               flash_d    = flash_step;
               led_out1_d = (flash_step < FL_ON) ? LAMP_YEL : LAMP_OFF;
               led_out2_d = (flash_step < FL_ON) ? LAMP_YEL : LAMP_OFF;
            end
         end
         ST_ALL_RED: begin
            allred_d = allred_step;
            if ((allred_step >= AR_MIN) && exit_ok) begin
               state_d    = ST_MON;
               led_out1_d = led_in1;
               led_out2_d = led_in2;
            end else begin
               led_out1_d = LAMP_RED;
               led_out2_d = LAMP_RED;
            end
         end
         default: begin
            state_d = ST_MON;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_MON;
      end else begin
         state_q <= state_d;
      end
   end

   // Output, fault-record and counter registers; reset drives all-red with
   // no fault recorded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_out1_q <= LAMP_RED;
         led_out2_q <= LAMP_RED;
         fault_q    <= 1'b0;
         code_q     <= FC_NONE;
         dir_q      <= 2'b00;
         flash_q    <= '0;
         allred_q   <= '0;
      end else begin
         led_out1_q <= led_out1_d;
         led_out2_q <= led_out2_d;
         fault_q    <= fault_d;
         code_q     <= code_d;
         dir_q      <= dir_d;
         flash_q    <= flash_d;
         allred_q   <= allred_d;
      end
   end

   assign led_out1   = led_out1_q;
   assign led_out2   = led_out2_q;
   assign fault      = fault_q;
   assign fault_code = code_q;
   assign fault_dir  = dir_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// ---------------------------------------------------------------------------
// tb_traffic_safety_monitor
// Self-checking bench for traffic_safety_monitor: a table of stateful
// vectors, hand-written multi-cycle sequences and a randomized controller
// run compared against a behavioural model of the monitor's rules.
// ---------------------------------------------------------------------------
module tb_traffic_safety_monitor;

   localparam int Y_MIN      = 5;
   localparam int Y_MAX      = 6;
   localparam int G_MAX      = 12;
   localparam int FLASH_DIV  = 4;
   localparam int ALLRED_CYC = 3;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   typedef struct {
      logic [2:0] in1;
      logic [2:0] in2;
      logic       clr;
      logic [2:0] e1;
      logic [2:0] e2;
      logic       ef;
      logic [2:0] ecode;
      logic [1:0] edir;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [2:0] led_in1;
   logic [2:0] led_in2;
   logic       fault_clr;
   logic [2:0] led_out1;
   logic [2:0] led_out2;
   logic       fault;
   logic [2:0] fault_code;
   logic [1:0] fault_dir;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [2:0] m_prev [2];
   int         m_run  [2];
   bit         m_faulted;
   bit         m_recover;
   int         m_flash_age;
   int         m_red_age;
   logic [2:0] m_out1;
   logic [2:0] m_out2;
   logic       m_fault;
   logic [2:0] m_code;
   logic [1:0] m_dir;

   vec_t tbl [25];

   traffic_safety_monitor #(
      .Y_MIN      (Y_MIN),
      .Y_MAX      (Y_MAX),
      .G_MAX      (G_MAX),
      .FLASH_DIV  (FLASH_DIV),
      .ALLRED_CYC (ALLRED_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .led_in1    (led_in1),
      .led_in2    (led_in2),
      .fault_clr  (fault_clr),
      .led_out1   (led_out1),
      .led_out2   (led_out2),
      .fault      (fault),
      .fault_code (fault_code),
      .fault_dir  (fault_dir)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit oneHot(input logic [2:0] v);
      return (v == R) || (v == Y) || (v == G);
   endfunction

   // Lowest fault code a single direction raises, 0 if none
   function automatic int dirCode(input logic [2:0] cur, input logic [2:0] prv, input int run);
      if (!oneHot(cur)) return 1;
      if (cur != prv) begin
         if (!((prv == R && cur == G) || (prv == G && cur == Y) || (prv == Y && cur == R)))
            return 3;
         if (prv == Y && run < Y_MIN) return 4;
         return 0;
      end
      if (cur == Y && run >= Y_MAX) return 5;
      if (cur == G && run >= G_MAX) return 6;
      return 0;
   endfunction

   function automatic vec_t mkVec(input logic [2:0] i1, input logic [2:0] i2, input logic c,
                                  input logic [2:0] o1, input logic [2:0] o2, input logic f,
                                  input logic [2:0] code, input logic [1:0] d);
      vec_t v;
      v.in1 = i1; v.in2 = i2; v.clr = c;
      v.e1 = o1; v.e2 = o2; v.ef = f; v.ecode = code; v.edir = d;
      return v;
   endfunction

   task automatic modelReset();
      m_prev[0] = R; m_prev[1] = R;
      m_run[0] = 0;  m_run[1] = 0;
      m_faulted = 0; m_recover = 0;
      m_flash_age = 0; m_red_age = 0;
      m_out1 = R; m_out2 = R;
      m_fault = 0; m_code = 0; m_dir = 0;
   endtask

   // One clock edge of the monitor's rules, in terms of "how long has each
   // lamp been shown" and "how long since the fault / since the clear".
   task automatic modelStep(input logic [2:0] in1, input logic [2:0] in2, input logic clr);
      int  c1, c2, win;
      bit  conf;
      logic [2:0] fl;
      c1 = dirCode(in1, m_prev[0], m_run[0]);
      c2 = dirCode(in2, m_prev[1], m_run[1]);
      conf = oneHot(in1) && oneHot(in2) && (in1 != R) && (in2 != R);
      win = 0;
      if (c1 == 1 || c2 == 1) win = 1;
      else if (conf) win = 2;
      else begin
         if (c1 != 0) win = c1;
         if (c2 != 0 && (win == 0 || c2 < win)) win = c2;
      end
      if (!m_faulted && !m_recover) begin
         if (win != 0) begin
            m_faulted = 1; m_fault = 1; m_code = 3'(win);
            m_dir = (win == 2) ? 2'b11 : {c2 == win, c1 == win};
            m_flash_age = 0;
            m_out1 = Y; m_out2 = Y;
         end else begin
            m_out1 = in1; m_out2 = in2;
         end
      end else if (m_faulted) begin
         if (clr) begin
            m_faulted = 0; m_recover = 1; m_red_age = 0;
            m_fault = 0; m_code = 0; m_dir = 0;
            m_out1 = R; m_out2 = R;
         end else begin
            m_flash_age++;
            fl = (((m_flash_age / FLASH_DIV) % 2) == 0) ? Y : O;
            m_out1 = fl; m_out2 = fl;
         end
      end else begin
         m_red_age++;
         if (m_red_age >= ALLRED_CYC && oneHot(in1) && oneHot(in2) && (in1 == R || in2 == R)) begin
            m_recover = 0;
            m_out1 = in1; m_out2 = in2;
         end else begin
            m_out1 = R; m_out2 = R;
         end
      end
      if (in1 != m_prev[0]) m_run[0] = 1; else if (m_run[0] < 1000) m_run[0]++;
      if (in2 != m_prev[1]) m_run[1] = 1; else if (m_run[1] < 1000) m_run[1]++;
      m_prev[0] = in1; m_prev[1] = in2;
   endtask

   // Drive inputs between edges, clock them in, advance the model, then
   // settle just past the edge for sampling.
   task automatic applyStimulus(input logic [2:0] in1, input logic [2:0] in2, input logic clr);
      led_in1   = in1;
      led_in2   = in2;
      fault_clr = clr;
      @(posedge clk);
      modelStep(in1, in2, clr);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] e1, input logic [2:0] e2,
                              input logic ef, input logic [2:0] ecode, input logic [1:0] edir);
      checks++;
      if (led_out1 !== e1 || led_out2 !== e2 || fault !== ef ||
          fault_code !== ecode || fault_dir !== edir) begin
         failures++;
         $display("[TB] FAIL %s: got out=%b/%b fault=%b code=%0d dir=%b, expected out=%b/%b fault=%b code=%0d dir=%b",
                  name, led_out1, led_out2, fault, fault_code, fault_dir, e1, e2, ef, ecode, edir);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, m_out1, m_out2, m_fault, m_code, m_dir);
   endtask

   task automatic doReset();
      rst       = 1'b1;
      led_in1   = R;
      led_in2   = R;
      fault_clr = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      modelReset();
      checkOutput("reset", R, R, 1'b0, 3'd0, 2'b00);
   endtask

   initial begin
      logic [2:0] a, b, r1, r2;
      logic       c;
      int         phase, left;

      rst       = 1'b1;
      led_in1   = R;
      led_in2   = R;
      fault_clr = 1'b0;
      modelReset();
      #1;
      checkOutput("reset_t0", R, R, 1'b0, 3'd0, 2'b00);

      // Stateful table: conflict, flash pattern, recovery, yellow short,
      // recovery blocked by unsafe inputs and by an illegal input
      tbl[0]  = mkVec(R, R, 0, R, R, 0, 0, 2'b00);
      tbl[1]  = mkVec(G, R, 0, G, R, 0, 0, 2'b00);
      tbl[2]  = mkVec(G, G, 0, Y, Y, 1, 2, 2'b11);
      tbl[3]  = mkVec(R, R, 0, Y, Y, 1, 2, 2'b11);
      tbl[4]  = mkVec(R, R, 0, Y, Y, 1, 2, 2'b11);
      tbl[5]  = mkVec(R, R, 0, Y, Y, 1, 2, 2'b11);
      tbl[6]  = mkVec(R, R, 0, O, O, 1, 2, 2'b11);
      tbl[7]  = mkVec(R, R, 0, O, O, 1, 2, 2'b11);
      tbl[8]  = mkVec(R, R, 0, O, O, 1, 2, 2'b11);
      tbl[9]  = mkVec(R, R, 0, O, O, 1, 2, 2'b11);
      tbl[10] = mkVec(G, R, 0, Y, Y, 1, 2, 2'b11);
      tbl[11] = mkVec(G, R, 1, R, R, 0, 0, 2'b00);
      tbl[12] = mkVec(G, R, 0, R, R, 0, 0, 2'b00);
      tbl[13] = mkVec(G, R, 0, R, R, 0, 0, 2'b00);
      tbl[14] = mkVec(G, R, 0, G, R, 0, 0, 2'b00);
      tbl[15] = mkVec(G, R, 0, G, R, 0, 0, 2'b00);
      tbl[16] = mkVec(Y, R, 0, Y, R, 0, 0, 2'b00);
      tbl[17] = mkVec(R, R, 0, Y, Y, 1, 4, 2'b01);
      tbl[18] = mkVec(G, G, 1, R, R, 0, 0, 2'b00);
      tbl[19] = mkVec(G, G, 1, R, R, 0, 0, 2'b00);
      tbl[20] = mkVec(G, G, 0, R, R, 0, 0, 2'b00);
      tbl[21] = mkVec(G, G, 0, R, R, 0, 0, 2'b00);
      tbl[22] = mkVec(3'b011, R, 0, R, R, 0, 0, 2'b00);
      tbl[23] = mkVec(R, G, 0, R, G, 0, 0, 2'b00);
      tbl[24] = mkVec(R, G, 0, R, G, 0, 0, 2'b00);

      $display("[TB] table vectors");
      doReset();
      for (int i = 0; i < 25; i++) begin
         applyStimulus(tbl[i].in1, tbl[i].in2, tbl[i].clr);
         checkOutput($sformatf("table[%0d]", i), tbl[i].e1, tbl[i].e2, tbl[i].ef,
                     tbl[i].ecode, tbl[i].edir);
      end

      // Three full controller cycles: dir1 G10/Y5/R15, dir2 complementary
      $display("[TB] normal cycle");
      doReset();
      for (int cyc = 0; cyc < 3; cyc++) begin
         for (int t = 0; t < 30; t++) begin
            a = (t < 10) ? G : (t < 15) ? Y : R;
            b = (t < 15) ? R : (t < 25) ? G : Y;
            applyStimulus(a, b, 1'b0);
            checkOutput($sformatf("normal[%0d]", cyc * 30 + t), a, b, 1'b0, 3'd0, 2'b00);
         end
      end

      // Yellow held for only 3 cycles before red
      $display("[TB] yellow short");
      doReset();
      applyStimulus(G, R, 1'b0);
      checkOutput("yshort_g", G, R, 1'b0, 3'd0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(Y, R, 1'b0);
         checkOutput("yshort_y", Y, R, 1'b0, 3'd0, 2'b00);
      end
      applyStimulus(R, R, 1'b0);
      checkOutput("yshort_fault", Y, Y, 1'b1, 3'd4, 2'b01);

      // Illegal encoding on dir2 beats dir1's illegal G->R in the same cycle
      $display("[TB] priority");
      doReset();
      applyStimulus(G, R, 1'b0);
      checkOutput("prio_g", G, R, 1'b0, 3'd0, 2'b00);
      applyStimulus(R, 3'b011, 1'b0);
      checkOutput("prio_fault", Y, Y, 1'b1, 3'd1, 2'b10);

      // Green watchdog boundary: 12 green samples pass, the 13th trips
      $display("[TB] green watchdog");
      doReset();
      for (int i = 0; i < G_MAX; i++) begin
         applyStimulus(G, R, 1'b0);
         checkOutput($sformatf("gwatch_ok[%0d]", i), G, R, 1'b0, 3'd0, 2'b00);
      end
      applyStimulus(G, R, 1'b0);
      checkOutput("gwatch_fault", Y, Y, 1'b1, 3'd6, 2'b01);

      // Yellow long boundary on dir2: 6 yellow samples pass, the 7th trips
      $display("[TB] yellow long");
      doReset();
      applyStimulus(R, G, 1'b0);
      checkOutput("ylong_g", R, G, 1'b0, 3'd0, 2'b00);
      for (int i = 0; i < Y_MAX; i++) begin
         applyStimulus(R, Y, 1'b0);
         checkOutput($sformatf("ylong_ok[%0d]", i), R, Y, 1'b0, 3'd0, 2'b00);
      end
      applyStimulus(R, Y, 1'b0);
      checkOutput("ylong_fault", Y, Y, 1'b1, 3'd5, 2'b10);

      // Asynchronous reset in the middle of a flash "on" phase
      $display("[TB] async reset");
      doReset();
      applyStimulus(G, R, 1'b0);
      applyStimulus(G, G, 1'b0);
      checkOutput("arst_enter", Y, Y, 1'b1, 3'd2, 2'b11);
      applyStimulus(G, G, 1'b0);
      checkOutput("arst_flash", Y, Y, 1'b1, 3'd2, 2'b11);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_immediate", R, R, 1'b0, 3'd0, 2'b00);
      #2;
      @(posedge clk);
      #2;
      rst = 1'b0;
      modelReset();
      led_in1 = R;
      led_in2 = R;
      // Previous value back at red makes R->Y an illegal transition
      applyStimulus(Y, R, 1'b0);
      checkOutput("arst_prev_red", Y, Y, 1'b1, 3'd3, 2'b01);

      // Randomized controller with varying phase lengths, occasional glitches
      // and random clear requests, compared against the model every cycle
      $display("[TB] random");
      doReset();
      phase = 0;
      left  = int'($urandom_range(9, 14));
      for (int n = 0; n < 3000; n++) begin
         case (phase)
            0:       begin r1 = G; r2 = R; end
            1:       begin r1 = Y; r2 = R; end
            3:       begin r1 = R; r2 = G; end
            4:       begin r1 = R; r2 = Y; end
            default: begin r1 = R; r2 = R; end
         endcase
         if ($urandom_range(0, 39) == 0) r1 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) r2 = 3'($urandom_range(0, 7));
         c = m_faulted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
         applyStimulus(r1, r2, c);
         checkModel($sformatf("random[%0d]", n));
         left--;
         if (left <= 0) begin
            phase = (phase + 1) % 6;
            case (phase)
               0, 3:    left = int'($urandom_range(9, 14));
               1, 4:    left = int'($urandom_range(3, 8));
               default: left = 1;
            endcase
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_safety_monitor.md
# traffic_safety_monitor

Runtime safety monitor downstream of the traffic-light controller. Consumes both lamp vectors, checks encoding, cross-direction conflict, transition order and phase durations, and forwards them to the lamp drivers with one cycle of latency. On the first violation it latches a fault code and forces both directions to flashing yellow. A clear request returns it through an all-red phase to normal pass-through.

## Interface
Parameters:
- `Y_MIN`, default 5: minimum legal yellow duration in cycles.
- `Y_MAX`, default 6: maximum legal yellow duration in cycles.
- `G_MAX`, default 12: green watchdog limit in cycles.
- `FLASH_DIV`, default 4: cycles per flash half-period.
- `ALLRED_CYC`, default 3: minimum all-red cycles after a clear.

Ports (lamp encoding is {R,Y,G}, one-hot):
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `led_in1` in 3: direction-1 lamps from the controller.
- `led_in2` in 3: direction-2 lamps from the controller.
- `fault_clr` in 1: fault clear request, level-sampled.
- `led_out1` out 3: direction-1 lamp drive.
- `led_out2` out 3: direction-2 lamp drive.
- `fault` out 1: fault latched.
- `fault_code` out 3: first fault cause. 0 = none.
- `fault_dir` out 2: direction(s) involved. Bit0 = dir1, bit1 = dir2.

## Operation
- States: MON, FAULT, ALL_RED. Reset state is MON.
- Reset values: `led_out1`/`led_out2` = 100, `fault` = 0, `fault_code` = 0, `fault_dir` = 0.
- Per-direction tracking runs in every state, on every edge:
  - `prev` register, reset 100.
  - Duration counter `cnt`, reset 0. Width is clog2(max(G_MAX,Y_MAX)+1). Saturates at all-ones.
  - If `led_in` != `prev`, then `cnt` <= 1. Otherwise `cnt` <= `cnt`+1.
  - `prev` <= `led_in`.
- Violation checks are combinational on `led_in` against `prev`/`cnt`. They are evaluated only in MON. Codes:
  - 1: illegal encoding, `led_in` not one-hot.
  - 2: conflict, both inputs legal and neither is 100.
  - 3: illegal transition. Legal changes are R→G, G→Y, Y→R only. Any other change is illegal.
  - 4: yellow short, Y→R with `cnt` < Y_MIN.
  - 5: yellow long, `led_in`=`prev`=Y with `cnt` ≥ Y_MAX.
  - 6: green watchdog, `led_in`=`prev`=G with `cnt` ≥ G_MAX.
- Multiple violations in one cycle: lowest code wins. `fault_dir` flags every direction showing the winning code. Code 2 sets `fault_dir` = 11.
- MON behaviour:
  - No violation: `led_out` <= `led_in`.
  - Violation: `fault` <= 1, code and dir latched, state <= FAULT, both `led_out` <= 010.
  - A violating input value never reaches `led_out`.
  - `fault_clr` is ignored.
- FAULT behaviour:
  - Both outputs flash: 010 for FLASH_DIV cycles, then 000 for FLASH_DIV cycles, repeating. The entry edge starts the first "on" phase.
  - Code and dir are held. Later violations do not overwrite them.
  - `fault_clr`=1 at an edge: state <= ALL_RED, `fault`/`fault_code`/`fault_dir` <= 0, outputs <= 100/100, flash counter cleared.
- ALL_RED behaviour:
  - Outputs are held at 100/100 and an all-red counter runs.
  - Exit to MON at the first edge where both hold: at least ALLRED_CYC cycles have been spent in ALL_RED, and both `led_in` are legal with at least one equal to 100.
  - On the exit edge `led_out` <= `led_in`.
  - `fault_clr` is ignored.
- `rst` asserted in any state immediately forces all registers to their reset values.

## Timing
- Pass-through latency in MON is 1 cycle.
- A fault and the failsafe output appear at the same edge that samples the violating input.
- FAULT→ALL_RED takes 1 edge after `fault_clr` is sampled high.
- ALL_RED lasts at least ALLRED_CYC cycles of 100/100.
- Flash period is 2·FLASH_DIV cycles.

## Structure
- Shared package `traffic_pkg` holds:
  - Lamp constants LAMP_RED=100, LAMP_YEL=010, LAMP_GRN=001, LAMP_OFF=000.
  - Fault code constants 0–6.
  - The state encoding.
  - The controller uses the same lamp constants.
- Sub-module `traffic_lamp_checker` is instantiated once per direction. It contains `prev`, `cnt`, and the codes 1, 3, 4, 5, 6 as one-hot violation flags.
- The top level contains:
  - The conflict check.
  - Priority encoding.
  - The FSM.
  - The flash and all-red counters.
  - The output registers.

## Test plan
- Normal cycle, dir1 G10→Y5→R15 with dir2 complementary, for 3 full cycles: `led_out` equals `led_in` delayed 1 cycle, and `fault` stays 0.
- Conflict, both inputs 001 in one cycle: at that edge `fault`=1, `fault_code`=2, `fault_dir`=11, outputs 010/010. Then with FLASH_DIV=4: 4 cycles 010, then 4 cycles 000, repeating.
- Yellow short, dir1 Y for 3 cycles then R: `fault_code`=4, `fault_dir`=01.
- Priority, dir2=011 in the same cycle as dir1 G→R: `fault_code`=1, `fault_dir`=10.
- Recovery, `fault_clr` pulse in FAULT with inputs 001/100:
  - Outputs 100/100 and `fault`=0 on the next edge.
  - Outputs held at 100/100 for 3 cycles, then follow `led_in`.
  - Repeat with inputs 001/001: the block stays in ALL_RED.
- Async `rst` asserted mid-flash between clock edges: outputs go to 100/100 and `fault`/`fault_code` go to 0 immediately. After release the block is in MON with `prev`=100.
